// File: rtl/key_pkg.sv
// Shared constants for the push-button conditioning block.
// Key indices let parents pick o_press/o_level bits by function rather than number.
package key_pkg;

    localparam int unsigned NUM_KEYS_DEFAULT    = 3;
    localparam int unsigned DEBOUNCE_20MS_50MHZ = 1000000;

    localparam int unsigned KEY_START = 0;
    localparam int unsigned KEY_RST   = 1;
    localparam int unsigned KEY_TRACE = 2;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stable-time counter, debounced level
// and registered single-cycle press/release pulses.
module key_debounce_ch #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH     = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_level;
    logic                 r_press;
    logic                 r_release;
    logic                 w_p;

    assign w_p = ~r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Any sample matching the accepted level restarts the stable window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_p == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt     <= '0;
                r_level   <= w_p;
                r_press   <= w_p;
                r_release <= ~w_p;
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS raw active-low buttons into clean levels and
// press/release strobes; each channel is fully independent.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS      = NUM_KEYS_DEFAULT,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int unsigned CNT_WIDTH     = 20
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_key_n,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_press,
    output logic [NUM_KEYS-1:0] o_release
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_WIDTH     (CNT_WIDTH)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_key_n   (i_key_n[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench: stimulus queues expected pulses with their edge number,
// a monitor checks every pulse, the level each cycle, and flags unexpected pulses.
module tb_key_debounce;
    import key_pkg::*;

    localparam int unsigned NK = 3;
    localparam int unsigned SC = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned LAT = SC + 2;

    typedef struct {
        int unsigned edge_no;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lvl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] release_p;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    int unsigned   edge_cnt = 0;
    exp_t          q[$];
    logic [NK-1:0] lvl_model = '0;

    key_debounce #(
        .NUM_KEYS      (NK),
        .STABLE_CYCLES (SC),
        .CNT_WIDTH     (CW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_key_n   (key_n),
        .o_level   (level),
        .o_press   (press),
        .o_release (release_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    task automatic expect_evt(input logic [NK-1:0] p, input logic [NK-1:0] r, input logic [NK-1:0] l);
        exp_t e;
        e.edge_no = edge_cnt + LAT;
        e.press   = p;
        e.rel     = r;
        e.lvl     = l;
        q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            if (!rst_n) begin
                lvl_model = '0;
            end else begin
                if ((press | release_p) != '0) begin
                    if (q.size() == 0) begin
                        check("unexpected_pulse_press", press, '0);
                        check("unexpected_pulse_release", release_p, '0);
                    end else begin
                        e = q.pop_front();
                        checks++;
                        if (edge_cnt != e.edge_no) begin
                            errors++;
                            $display("FAIL pulse_edge: got edge %0d expected edge %0d", edge_cnt, e.edge_no);
                        end
                        check("pulse_press", press, e.press);
                        check("pulse_release", release_p, e.rel);
                        lvl_model = e.lvl;
                    end
                end
                check("press_release_overlap", press & release_p, '0);
                check("level", level, lvl_model);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        repeat (3) @(negedge clk);
        check("reset_level", level, '0);
        check("reset_press", press, '0);
        check("reset_release", release_p, '0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single press on key0 held, then release
        key_n[KEY_START] = 1'b0;
        expect_evt(3'b001, 3'b000, 3'b001);
        repeat (12) @(negedge clk);
        key_n[KEY_START] = 1'b1;
        expect_evt(3'b000, 3'b001, 3'b000);
        repeat (12) @(negedge clk);

        // Bounce: low 3, high 1, then low and held
        key_n[KEY_START] = 1'b0;
        repeat (3) @(negedge clk);
        key_n[KEY_START] = 1'b1;
        @(negedge clk);
        key_n[KEY_START] = 1'b0;
        expect_evt(3'b001, 3'b000, 3'b001);
        repeat (12) @(negedge clk);
        key_n[KEY_START] = 1'b1;
        expect_evt(3'b000, 3'b001, 3'b000);
        repeat (12) @(negedge clk);

        // Simultaneous keys 0 and 2
        key_n[KEY_START] = 1'b0;
        key_n[KEY_TRACE] = 1'b0;
        expect_evt(3'b101, 3'b000, 3'b101);
        repeat (12) @(negedge clk);
        key_n = '1;
        expect_evt(3'b000, 3'b101, 3'b000);
        repeat (12) @(negedge clk);

        // Key1 held through an asynchronous reset
        key_n[KEY_RST] = 1'b0;
        expect_evt(3'b010, 3'b000, 3'b010);
        repeat (10) @(negedge clk);
        check("pre_reset_level", level, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_level", level, '0);
        check("async_reset_press", press, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_evt(3'b010, 3'b000, 3'b010);
        repeat (12) @(negedge clk);
        key_n[KEY_RST] = 1'b1;
        expect_evt(3'b000, 3'b010, 3'b000);
        repeat (12) @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_pulses: got %0d outstanding expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
